// File: rtl/mult_arbiter.sv
// rtl/mult_arbiter.sv - round-robin arbiter sequencing a shift-add multiplier datapath for 4 requesters
module mult_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  req,
    input  logic [63:0] opa,
    input  logic [63:0] opb,
    output logic [3:0]  gnt,
    output logic [3:0]  ack,
    output logic [15:0] result,
    output logic        busy,
    output logic        lda,
    output logic        ldb,
    output logic        ldp,
    output logic        clrp,
    output logic        decb,
    output logic [15:0] data,
    input  logic        eqz,
    input  logic [15:0] prod
);

    typedef enum logic [2:0] {IDLE, LDA, LDB, ADD, DONE} state_t;

    state_t     state;
    logic [1:0] ptr;
    logic [1:0] gidx;
    logic [1:0] pick;
    logic       found;
    logic [1:0] idx;

    function automatic logic [15:0] sel16(input logic [63:0] v, input logic [1:0] i);
        logic [15:0] r;
        case (i)
            2'd0:    r = v[15:0];
            2'd1:    r = v[31:16];
            2'd2:    r = v[47:32];
            default: r = v[63:48];
        endcase
        return r;
    endfunction

    // Search upward from ptr, wrapping modulo 4; first requester found wins.
    always_comb begin
        pick  = ptr;
        found = 1'b0;
        idx   = ptr;
        for (int i = 0; i < 4; i++) begin
            idx = ptr + 2'(i);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    // Add/decrement strobes follow eqz within the same cycle so ADD runs B+1 cycles.
    assign ldp  = (state == ADD) && !eqz;
    assign decb = (state == ADD) && !eqz;
    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            ptr    <= 2'd0;
            gidx   <= 2'd0;
            gnt    <= 4'b0000;
            ack    <= 4'b0000;
            result <= 16'h0000;
            lda    <= 1'b0;
            ldb    <= 1'b0;
            clrp   <= 1'b0;
            data   <= 16'h0000;
        end else begin
            lda  <= 1'b0;
            ldb  <= 1'b0;
            clrp <= 1'b0;
            data <= 16'h0000;
            ack  <= 4'b0000;
            case (state)
                IDLE: begin
                    if (found) begin
                        gidx  <= pick;
                        gnt   <= 4'b0001 << pick;
                        lda   <= 1'b1;
                        data  <= sel16(opa, pick);
                        state <= LDA;
                    end
                end
                LDA: begin
                    ldb   <= 1'b1;
                    clrp  <= 1'b1;
                    data  <= sel16(opb, gidx);
                    state <= LDB;
                end
                LDB: begin
                    state <= ADD;
                end
                ADD: begin
                    if (eqz) begin
                        result <= prod;
                        ack    <= gnt;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    gnt   <= 4'b0000;
                    ptr   <= gidx + 2'd1;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_arbiter.sv
// tb/tb_mult_arbiter.sv - directed scoreboard bench for mult_arbiter with a behavioural multiplier datapath
module tb_mult_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [63:0] opa, opb;
    logic [3:0]  gnt, ack;
    logic [15:0] result, data, prod;
    logic        busy, lda, ldb, ldp, clrp, decb, eqz;

    int vectors = 0;
    int errs    = 0;
    int cyc     = 0;

    typedef struct {
        logic [3:0]  mask;
        logic [15:0] res;
        int          lat;
    } exp_t;
    exp_t sb[$];

    mult_arbiter dut (
        .clk(clk), .rst_n(rst_n), .req(req), .opa(opa), .opb(opb),
        .gnt(gnt), .ack(ack), .result(result), .busy(busy),
        .lda(lda), .ldb(ldb), .ldp(ldp), .clrp(clrp), .decb(decb),
        .data(data), .eqz(eqz), .prod(prod)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Multiplier datapath: A register, B down-counter, P accumulator.
    logic [15:0] ra = '0, rb = '0, rp = '0;
    always @(posedge clk) begin
        if (lda) ra <= data;
        if (ldb) rb <= data;
        else if (decb) rb <= rb - 16'd1;
        if (clrp) rp <= '0;
        else if (ldp) rp <= rp + ra;
    end
    assign eqz  = (rb == 16'd0);
    assign prod = rp;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_ops(input int k, input logic [15:0] a, input logic [15:0] b);
        opa[16*k +: 16] = a;
        opb[16*k +: 16] = b;
    endtask

    task automatic do_req(input int k, input logic [15:0] a, input logic [15:0] b, input int drop_at);
        exp_t e, g;
        logic [15:0] r;
        int t0, n, ldps, decbs, gcyc;
        bit got;
        set_ops(k, a, b);
        req[k] = 1'b1;
        t0 = cyc;
        r = a * b;
        e.mask = 4'b0001 << k;
        e.res  = r;
        e.lat  = int'(b) + 4;
        sb.push_back(e);
        got = 0; n = 0; ldps = 0; decbs = 0; gcyc = 0;
        while (!got && n < 1000) begin
            @(negedge clk);
            n++;
            if (n == 1) chk("lda_phase", {lda, ldb, clrp, data}, {3'b100, a});
            if (n == 2) chk("ldb_phase", {lda, ldb, clrp, data}, {3'b011, b});
            if (n == drop_at) req[k] = 1'b0;
            if (ldp) ldps++;
            if (decb) decbs++;
            if (gnt === e.mask) gcyc++;
            if (ack !== 4'b0000) got = 1;
        end
        chk("ack_seen", got, 1);
        chk("sb_pop", sb.size() != 0, 1);
        if (got && sb.size() != 0) begin
            g = sb.pop_front();
            chk("ack_mask", ack, g.mask);
            chk("result", result, g.res);
            chk("latency", cyc - t0, g.lat);
            chk("ldp_count", ldps, b);
            chk("decb_count", decbs, b);
            chk("gnt_cycles", gcyc, g.lat);
        end
        req[k] = 1'b0;
        @(negedge clk);
        chk("post_idle", {gnt, ack, busy}, 9'd0);
    endtask

    task automatic multi(input logic [3:0] mask, input bit rereq, input int nops);
        exp_t g;
        int n, done;
        for (int i = 0; i < 4; i++) set_ops(i, 16'(i + 1), 16'(i + 1));
        req = mask;
        n = 0; done = 0;
        while (done < nops && n < 2000) begin
            @(negedge clk);
            n++;
            if (ack !== 4'b0000) begin
                chk("sb_pop", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    g = sb.pop_front();
                    chk("order_ack", ack, g.mask);
                    chk("order_result", result, g.res);
                    req = req & ~g.mask;
                    done++;
                    if (done == nops) req = 4'b0000;
                    else if (rereq) begin
                        @(negedge clk);
                        n++;
                        req = req | g.mask;
                    end
                end
            end
        end
        chk("multi_done", done, nops);
        req = 4'b0000;
        repeat (2) @(negedge clk);
        chk("multi_idle", {gnt, busy}, 5'd0);
    endtask

    function automatic exp_t mk(input logic [3:0] m, input logic [15:0] r);
        exp_t e;
        e.mask = m;
        e.res  = r;
        e.lat  = 0;
        return e;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        req   = 4'b0000;
        opa   = '0;
        opb   = '0;
        repeat (3) @(negedge clk);
        chk("reset_state", {gnt, ack, busy, result, data, lda, ldb, ldp, clrp, decb}, 0);
        rst_n = 1'b1;

        do_req(0, 16'd3, 16'd4, 0);
        do_req(1, 16'd7, 16'd0, 0);
        do_req(2, 16'd9, 16'd5, 2);

        sb.push_back(mk(4'b1000, 16'd16));
        multi(4'b1011, 1'b0, 1);

        sb.push_back(mk(4'b0001, 16'd1));
        sb.push_back(mk(4'b0010, 16'd4));
        sb.push_back(mk(4'b0100, 16'd9));
        sb.push_back(mk(4'b1000, 16'd16));
        sb.push_back(mk(4'b0001, 16'd1));
        multi(4'b1111, 1'b1, 5);

        do_req(0, 16'h0100, 16'h0100, 0);

        set_ops(0, 16'd5, 16'd10);
        req = 4'b0001;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("reset_mid_add", {gnt, ack, busy, result, data, lda, ldb, ldp, clrp, decb}, 0);
        req = 4'b0000;
        repeat (2) begin
            @(negedge clk);
            chk("no_ack_in_reset", ack, 4'b0000);
        end
        rst_n = 1'b1;
        do_req(0, 16'd2, 16'd3, 0);

        chk("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
